irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of external interrupt lines (1..8).
REQ-002 SHALL have parameter VEC_BASE, default 16'h0040, vector address of line 0.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16, cycles in WAIT_ACK before re-fire (2..255).
REQ-004 SHALL have parameter HOLDOFF, default 2, idle cycles after an acknowledge (0..15).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port irq_in  input  NUM_IRQ  asynchronous external requests, active-high.
REQ-008 SHALL have port mask_wr  input  1  write strobe for the enable mask.
REQ-009 SHALL have port mask_data  input  NUM_IRQ  new enable mask, 1 = enabled.
REQ-010 SHALL have port ack  input  1  one-cycle acknowledge from the processor.
REQ-011 SHALL have port ext_data  input  16  normal peripheral data.
REQ-012 SHALL have port interrupt  output  1  one-cycle pulse to the processor interrupt input.
REQ-013 SHALL have port data_in  output  16  processor data_in; vector while vec_valid, else ext_data.
REQ-014 SHALL have port vec_valid  output  1  high in FIRE and WAIT_ACK.
REQ-015 SHALL have port pending  output  NUM_IRQ  current pending register.

Function
REQ-016 Each irq_in bit SHALL pass through a two-flop synchronizer followed by a rising-edge detector, giving a 3-cycle input-to-pending latency.
REQ-017 A detected edge SHALL set its pending bit; pending bits SHALL clear only on ack of that id or on reset.
REQ-018 If an edge and an ack-clear hit the same bit in one cycle, set SHALL win.
REQ-019 mask_wr SHALL load mask_data into the mask register the next edge; masking SHALL NOT clear pending.
REQ-020 Eligible = pending AND mask; the lowest-index eligible bit SHALL have priority.
REQ-021 FSM states SHALL be IDLE, FIRE, WAIT_ACK, HOLDOFF.
REQ-022 IDLE: with any bit eligible, latch its id and go to FIRE next cycle; otherwise stay.
REQ-023 FIRE: interrupt=1 for exactly this cycle; load the timeout counter with ACK_TIMEOUT; go to WAIT_ACK.
REQ-024 WAIT_ACK: on ack, clear pending[id] and go to HOLDOFF; otherwise decrement the counter and on reaching 0 go to FIRE (re-fire, same id).
REQ-025 A mask change during WAIT_ACK SHALL NOT abort the in-flight request; a higher-priority edge SHALL NOT preempt it.
REQ-026 HOLDOFF: count HOLDOFF cycles, then go to IDLE; HOLDOFF=0 SHALL go to IDLE after one cycle.
REQ-027 An ack in IDLE, FIRE or HOLDOFF SHALL be ignored and clear nothing.
REQ-028 Vector SHALL be VEC_BASE + 4*id, computed modulo 2^16 (wraps silently).
REQ-029 data_in SHALL be a combinational mux: vector when vec_valid=1, ext_data otherwise.

Reset
REQ-030 While reset=0 at a clk edge: state=IDLE, interrupt=0, vec_valid=0, pending=0, mask=0, synchronizers=0, counters=0, latched id=0.
REQ-031 Reset mid-request (FIRE/WAIT_ACK) SHALL drop the request; no interrupt pulse SHALL appear in the cycle after reset release.
REQ-032 Lines already high at reset release SHALL NOT register an edge until they go low and high again.

Structure
REQ-033 State encoding and the VEC_BASE default SHALL live in a shared mips_pkg package.
REQ-034 The per-line synchronizer plus edge detector SHALL be one sub-module, irq_sync_edge, instantiated NUM_IRQ times.

Verification
REQ-035 mask=4'hF, pulse irq_in[2] -> pending=4'b0100 3 cycles later, interrupt pulse one cycle later, data_in=16'h0048 until ack.
REQ-036 Simultaneous edges on lines 1 and 3 -> line 1 served first (vector 16'h0044); after ack plus 2 holdoff cycles, line 3 fires (16'h004C).
REQ-037 No ack for 16 cycles in WAIT_ACK -> second interrupt pulse, same vector, pending unchanged.
REQ-038 mask=0, edge on line 0 -> pending=1, no interrupt; write mask=1 -> interrupt within 2 cycles.
REQ-039 Assert reset=0 during WAIT_ACK -> all outputs 0 next cycle, data_in=ext_data, no pulse after release.
REQ-040 Edge on line 0 coincident with its ack -> pending[0] remains 1 and line 0 re-fires after holdoff.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the interrupt controller slice:
//   - FSM state encoding of irq_ctrl (legacy-compatible constants)
//   - default vector base address
//   - helpers: lowest-index priority pick and vector address formation
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_FIRE     = 2'd1;
   localparam logic [1:0] ST_WAIT_ACK = 2'd2;
   localparam logic [1:0] ST_HOLDOFF  = 2'd3;

   localparam logic [15:0] VEC_BASE_DEFAULT = 16'h0040;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [2:0] lowest_set(input logic [7:0] bits);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (bits[7 - i]) idx = 3'(7 - i);
      end
      return idx;
   endfunction

   // Vector address = base + 4*id, wrapping modulo 2^16.
   function automatic logic [15:0] vector_addr(input logic [15:0] base,
                                               input logic [2:0]  id);
      return base + {11'd0, id, 2'b00};
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// Two-flop synchronizer plus rising-edge detector for one interrupt line.
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous, active-low reset
//   irq   - asynchronous external request, active-high
//   rise  - one-cycle pulse when a low-to-high transition has been seen
// -----------------------------------------------------------------------------
module irq_sync_edge
   import mips_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic irq,
   output logic rise
);

   logic meta;
   logic sync;
   logic prev;
   logic live;
   logic armed;

   // live marks that meta holds a real sample rather than its reset value;
   // armed is set only once the line has really been observed low, so a line
   // already high when reset releases does not produce a spurious edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta  <= 1'b0;
         sync  <= 1'b0;
         prev  <= 1'b0;
         live  <= 1'b0;
         armed <= 1'b0;
      end else begin
         meta  <= irq;
         sync  <= meta;
         prev  <= sync;
         live  <= 1'b1;
         armed <= armed | (live & ~meta);
      end
   end

   assign rise = sync & ~prev & armed;

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Prioritised vectored interrupt controller: synchronises and edge-detects
// NUM_IRQ request lines, holds them pending until acknowledged, fires a
// one-cycle interrupt pulse for the lowest-index enabled pending line, and
// presents its vector on data_in until the processor acknowledges.
// Ports:
//   clk       - sole clock, rising edge
//   reset     - synchronous, active-low reset
//   irq_in    - asynchronous external requests, active-high
//   mask_wr   - write strobe for the enable mask
//   mask_data - new enable mask, 1 = enabled
//   ack       - one-cycle acknowledge from the processor
//   ext_data  - normal peripheral data
//   interrupt - one-cycle pulse to the processor interrupt input
//   data_in   - vector while vec_valid, else ext_data
//   vec_valid - high in FIRE and WAIT_ACK
//   pending   - current pending register
// -----------------------------------------------------------------------------
module irq_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned NUM_IRQ     = 4,
   parameter logic [15:0] VEC_BASE    = VEC_BASE_DEFAULT,
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter int unsigned HOLDOFF     = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_wr,
   input  logic [NUM_IRQ-1:0] mask_data,
   input  logic               ack,
   input  logic [15:0]        ext_data,
   output logic               interrupt,
   output logic [15:0]        data_in,
   output logic               vec_valid,
   output logic [NUM_IRQ-1:0] pending
);

   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] pending_q;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] clr;
   logic [1:0]         state;
   logic [2:0]         id;
   logic [7:0]         cnt;
   logic               take;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
      irq_sync_edge u_sync (
         .clk   (clk),
         .reset (reset),
         .irq   (irq_in[g]),
         .rise  (rise[g])
      );
   end

   assign eligible = pending_q & mask;

   // Only an ack while waiting for one clears anything.
   always_comb begin
      take = (state == ST_WAIT_ACK) && ack;
      clr  = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         clr[i] = take && (id == 3'(i));
      end
   end

   // A new edge overrides a same-cycle acknowledge clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pending_q <= '0;
         mask      <= '0;
      end else begin
         pending_q <= (pending_q & ~clr) | rise;
         if (mask_wr) mask <= mask_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
         id    <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|eligible) begin
                  id    <= lowest_set(8'(eligible));
                  state <= ST_FIRE;
               end
            end
            ST_FIRE: begin
               cnt   <= 8'(ACK_TIMEOUT);
               state <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (ack) begin
                  cnt   <= 8'(HOLDOFF);
                  state <= ST_HOLDOFF;
               end else begin
                  cnt <= cnt - 8'd1;
                  if (cnt == 8'd1) state <= ST_FIRE;
               end
            end
            ST_HOLDOFF: begin
               // HOLDOFF of 0 or 1 both leave after a single cycle.
               if (cnt <= 8'd1) state <= ST_IDLE;
               else             cnt   <= cnt - 8'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign interrupt = (state == ST_FIRE);
   assign vec_valid = (state == ST_FIRE) || (state == ST_WAIT_ACK);
   assign data_in   = vec_valid ? vector_addr(VEC_BASE, id) : ext_data;
   assign pending   = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic,
// each cycle compared against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

   localparam int N      = 4;
   localparam int ACK_TO = 16;
   localparam int HOLD   = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] irq_in = '0;
   logic         mask_wr = 1'b0;
   logic [N-1:0] mask_data = '0;
   logic         ack = 1'b0;
   logic [15:0]  ext_data = '0;
   logic         interrupt;
   logic [15:0]  data_in;
   logic         vec_valid;
   logic [N-1:0] pending;

   int n_vec = 0;
   int n_err = 0;

   irq_ctrl #(
      .NUM_IRQ     (N),
      .VEC_BASE    (16'h0040),
      .ACK_TIMEOUT (ACK_TO),
      .HOLDOFF     (HOLD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .irq_in    (irq_in),
      .mask_wr   (mask_wr),
      .mask_data (mask_data),
      .ack       (ack),
      .ext_data  (ext_data),
      .interrupt (interrupt),
      .data_in   (data_in),
      .vec_valid (vec_valid),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_FIRE, M_WAIT, M_HOLD} mphase_t;
   mphase_t      ph = M_IDLE;
   int           m_id = 0;
   int           waited = 0;
   int           held = 0;
   logic [N-1:0] m_pend = '0;
   logic [N-1:0] m_mask = '0;
   logic [N-1:0] samp[$];   // irq_in sampled at every clock since reset release

   // Advance one clock and update the model from the inputs applied to it.
   task automatic tick();
      logic [N-1:0] rises;
      logic [N-1:0] elig;
      int k;
      @(posedge clk);
      if (!reset) begin
         ph = M_IDLE; m_id = 0; waited = 0; held = 0;
         m_pend = '0; m_mask = '0;
         samp.delete();
      end else begin
         // A line counts as risen once a real low sample is followed by a
         // high sample; it reaches pending two clocks after the high sample.
         k = samp.size();
         rises = '0;
         if (k >= 3) rises = samp[k-2] & ~samp[k-3];
         samp.push_back(irq_in);
         elig = m_pend & m_mask;
         case (ph)
            M_IDLE: if (elig != 0) begin
               for (int i = N-1; i >= 0; i--) if (elig[i]) m_id = i;
               ph = M_FIRE;
            end
            M_FIRE: begin waited = 0; ph = M_WAIT; end
            M_WAIT: if (ack) begin
               m_pend[m_id] = 1'b0; held = 0; ph = M_HOLD;
            end else begin
               waited++;
               if (waited == ACK_TO) ph = M_FIRE;
            end
            M_HOLD: begin
               held++;
               if (held >= ((HOLD > 0) ? HOLD : 1)) ph = M_IDLE;
            end
         endcase
         m_pend |= rises;
         if (mask_wr) m_mask = mask_data;
      end
      #1;
   endtask

   function automatic logic [21:0] expect_v();
      logic f, v;
      f = (ph == M_FIRE);
      v = f || (ph == M_WAIT);
      return {f, v, m_pend, v ? 16'(16'h0040 + 4*m_id) : ext_data};
   endfunction

   // step encoding: [10]=reset [9]=ack [8]=mask_wr [7:4]=mask_data [3:0]=irq_in
   task automatic drive(input logic [10:0] s);
      reset     = s[10];
      ack       = s[9];
      mask_wr   = s[8];
      mask_data = s[7:4];
      irq_in    = s[3:0];
      ext_data  = 16'($urandom);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [10:0] st[] = '{11'h001, 11'h001, 11'h5F1, 11'h401, 11'h401, 11'h401,
                            11'h401, 11'h401, 11'h400, 11'h401, 11'h401, 11'h401,
                            11'h401, 11'h401, 11'h601, 11'h401, 11'h401, 11'h401};
      logic [21:0] o, e;
      foreach (st[i]) begin
         drive(st[i]); tick();
         o = {interrupt, vec_valid, pending, data_in}; e = expect_v();
         n_vec++;
         if (o !== e) begin n_err++; $display("FAIL reset[%0d] model: got %h expected %h", i, o, e); end
         if (i <= 1) begin
            n_vec++;
            if (o !== {6'b0, ext_data}) begin n_err++; $display("FAIL reset[%0d] outputs: got %h expected %h", i, o, {6'b0, ext_data}); end
         end
         if (i >= 2 && i <= 8) begin
            n_vec++;
            if (pending !== 4'b0 || interrupt !== 1'b0) begin n_err++; $display("FAIL high_at_release[%0d]: pending %b int %b expected 0000 0", i, pending, interrupt); end
         end
         if (i == 11) begin
            n_vec++;
            if (pending !== 4'b0001) begin n_err++; $display("FAIL reedge_pending: got %b expected 0001", pending); end
         end
         if (i == 12) begin
            n_vec++;
            if (interrupt !== 1'b1 || data_in !== 16'h0040) begin n_err++; $display("FAIL reedge_fire: int %b data %h expected 1 0040", interrupt, data_in); end
         end
      end
   endtask

   task automatic test_single();
      logic [10:0] st[] = '{11'h5F0, 11'h404, 11'h400, 11'h400, 11'h400, 11'h400, 11'h400,
                            11'h400, 11'h400, 11'h600, 11'h400, 11'h400, 11'h400};
      logic [21:0] o, e;
      foreach (st[i]) begin
         drive(st[i]); tick();
         o = {interrupt, vec_valid, pending, data_in}; e = expect_v();
         n_vec++;
         if (o !== e) begin n_err++; $display("FAIL single[%0d] model: got %h expected %h", i, o, e); end
         if (i == 3) begin
            n_vec++;
            if (pending !== 4'b0100 || interrupt !== 1'b0) begin n_err++; $display("FAIL single_latency: pending %b int %b expected 0100 0", pending, interrupt); end
         end
         if (i == 4) begin
            n_vec++;
            if (interrupt !== 1'b1 || data_in !== 16'h0048) begin n_err++; $display("FAIL single_fire: int %b data %h expected 1 0048", interrupt, data_in); end
         end
         if (i >= 5 && i <= 8) begin
            n_vec++;
            if (interrupt !== 1'b0 || vec_valid !== 1'b1 || data_in !== 16'h0048) begin n_err++; $display("FAIL single_wait[%0d]: int %b vv %b data %h expected 0 1 0048", i, interrupt, vec_valid, data_in); end
         end
         if (i == 9) begin
            n_vec++;
            if (pending !== 4'b0 || vec_valid !== 1'b0 || data_in !== ext_data) begin n_err++; $display("FAIL single_ack: pending %b vv %b data %h expected 0000 0 %h", pending, vec_valid, data_in, ext_data); end
         end
      end
   endtask

   task automatic test_priority();
      logic [10:0] st[] = '{11'h40A, 11'h400, 11'h400, 11'h400, 11'h400, 11'h600, 11'h400, 11'h400,
                            11'h400, 11'h400, 11'h600, 11'h400, 11'h400, 11'h400, 11'h400};
      logic [21:0] o, e;
      foreach (st[i]) begin
         drive(st[i]); tick();
         o = {interrupt, vec_valid, pending, data_in}; e = expect_v();
         n_vec++;
         if (o !== e) begin n_err++; $display("FAIL priority[%0d] model: got %h expected %h", i, o, e); end
         if (i == 2) begin
            n_vec++;
            if (pending !== 4'b1010) begin n_err++; $display("FAIL prio_pending: got %b expected 1010", pending); end
         end
         if (i == 3) begin
            n_vec++;
            if (interrupt !== 1'b1 || data_in !== 16'h0044) begin n_err++; $display("FAIL prio_first: int %b data %h expected 1 0044", interrupt, data_in); end
         end
         if (i == 6 || i == 7) begin
            n_vec++;
            if (interrupt !== 1'b0 || vec_valid !== 1'b0) begin n_err++; $display("FAIL prio_holdoff[%0d]: int %b vv %b expected 0 0", i, interrupt, vec_valid); end
         end
         if (i == 8) begin
            n_vec++;
            if (interrupt !== 1'b1 || data_in !== 16'h004C || pending !== 4'b1000) begin n_err++; $display("FAIL prio_second: int %b data %h pending %b expected 1 004c 1000", interrupt, data_in, pending); end
         end
      end
   endtask

   task automatic test_timeout();
      logic [10:0] st[27];
      logic [21:0] o, e;
      foreach (st[i]) st[i] = 11'h400;
      st[0]  = 11'h401;
      st[22] = 11'h600;
      foreach (st[i]) begin
         drive(st[i]); tick();
         o = {interrupt, vec_valid, pending, data_in}; e = expect_v();
         n_vec++;
         if (o !== e) begin n_err++; $display("FAIL timeout[%0d] model: got %h expected %h", i, o, e); end
         if (i >= 4 && i <= 19) begin
            n_vec++;
            if (interrupt !== 1'b0 || vec_valid !== 1'b1) begin n_err++; $display("FAIL timeout_wait[%0d]: int %b vv %b expected 0 1", i, interrupt, vec_valid); end
         end
         if (i == 3 || i == 20) begin
            n_vec++;
            if (interrupt !== 1'b1 || data_in !== 16'h0040 || pending !== 4'b0001) begin n_err++; $display("FAIL timeout_fire[%0d]: int %b data %h pending %b expected 1 0040 0001", i, interrupt, data_in, pending); end
         end
      end
   endtask

   task automatic test_mask();
      logic [10:0] st[] = '{11'h500, 11'h401, 11'h400, 11'h400, 11'h400, 11'h400, 11'h510,
                            11'h400, 11'h400, 11'h600, 11'h400, 11'h400, 11'h400, 11'h400};
      logic [21:0] o, e;
      foreach (st[i]) begin
         drive(st[i]); tick();
         o = {interrupt, vec_valid, pending, data_in}; e = expect_v();
         n_vec++;
         if (o !== e) begin n_err++; $display("FAIL mask[%0d] model: got %h expected %h", i, o, e); end
         if (i >= 3 && i <= 6) begin
            n_vec++;
            if (pending !== 4'b0001 || interrupt !== 1'b0) begin n_err++; $display("FAIL mask_blocked[%0d]: pending %b int %b expected 0001 0", i, pending, interrupt); end
         end
         if (i == 7) begin
            n_vec++;
            if (interrupt !== 1'b1 || data_in !== 16'h0040) begin n_err++; $display("FAIL mask_enable_fire: int %b data %h expected 1 0040", interrupt, data_in); end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [10:0] st[] = '{11'h5F0, 11'h402, 11'h400, 11'h400, 11'h400, 11'h400, 11'h400,
                            11'h000, 11'h400, 11'h400, 11'h400, 11'h400, 11'h400, 11'h400};
      logic [21:0] o, e;
      foreach (st[i]) begin
         drive(st[i]); tick();
         o = {interrupt, vec_valid, pending, data_in}; e = expect_v();
         n_vec++;
         if (o !== e) begin n_err++; $display("FAIL mid_reset[%0d] model: got %h expected %h", i, o, e); end
         if (i == 4) begin
            n_vec++;
            if (interrupt !== 1'b1 || data_in !== 16'h0044) begin n_err++; $display("FAIL mid_reset_fire: int %b data %h expected 1 0044", interrupt, data_in); end
         end
         if (i == 6) begin
            n_vec++;
            if (vec_valid !== 1'b1) begin n_err++; $display("FAIL mid_reset_wait: vv %b expected 1", vec_valid); end
         end
         if (i >= 7) begin
            n_vec++;
            if (o !== {6'b0, ext_data}) begin n_err++; $display("FAIL mid_reset_drop[%0d]: got %h expected %h", i, o, {6'b0, ext_data}); end
         end
      end
   endtask

   task automatic test_coincident();
      logic [10:0] st[18];
      logic [21:0] o, e;
      foreach (st[i]) st[i] = 11'h400;
      st[0]  = 11'h5F1;
      st[6]  = 11'h401;
      st[8]  = 11'h600;
      st[13] = 11'h600;
      foreach (st[i]) begin
         drive(st[i]); tick();
         o = {interrupt, vec_valid, pending, data_in}; e = expect_v();
         n_vec++;
         if (o !== e) begin n_err++; $display("FAIL coincident[%0d] model: got %h expected %h", i, o, e); end
         if (i == 8) begin
            n_vec++;
            if (pending !== 4'b0001 || vec_valid !== 1'b0) begin n_err++; $display("FAIL coinc_set_wins: pending %b vv %b expected 0001 0", pending, vec_valid); end
         end
         if (i == 11) begin
            n_vec++;
            if (interrupt !== 1'b1 || data_in !== 16'h0040) begin n_err++; $display("FAIL coinc_refire: int %b data %h expected 1 0040", interrupt, data_in); end
         end
         if (i == 13) begin
            n_vec++;
            if (pending !== 4'b0000) begin n_err++; $display("FAIL coinc_final_ack: pending %b expected 0000", pending); end
         end
      end
   endtask

   task automatic test_random();
      logic [21:0] o, e;
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(0, 149) != 0);
         ack       = ($urandom_range(0, 3) == 0);
         mask_wr   = ($urandom_range(0, 11) == 0);
         mask_data = 4'($urandom);
         for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
         ext_data  = 16'($urandom);
         tick();
         o = {interrupt, vec_valid, pending, data_in}; e = expect_v();
         n_vec++;
         if (o !== e) begin n_err++; $display("FAIL random[%0d] model: got %h expected %h", i, o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_timeout();
      test_mask();
      test_mid_reset();
      test_coincident();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
